plc_input_filter: RTL



---
 rtl/plc_input_filter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/plc_input_filter.sv
// Field-input conditioning: two-flop synchroniser, per-channel debounce, and a
// scan-handshaked process image with sticky rise/fall flags between scans.
module plc_input_filter #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] RAW_INPUTS,
  input  logic             FILTER_EN,
  input  logic             SCAN_REQ,
  output logic             SCAN_ACK,
  output logic [WIDTH-1:0] INPUTS,
  output logic [WIDTH-1:0] RISE_FLAGS,
  output logic [WIDTH-1:0] FALL_FLAGS,
  output logic [WIDTH-1:0] STABLE
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURE  = 2'd1,
    ACK      = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] w_stable_next;
  logic [CNT_W-1:0] r_cnt      [WIDTH];
  logic [CNT_W-1:0] w_cnt_next [WIDTH];
  logic [WIDTH-1:0] r_rise_pend;
  logic [WIDTH-1:0] r_fall_pend;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] r_inputs;
  logic [WIDTH-1:0] r_rise_flags;
  logic [WIDTH-1:0] r_fall_flags;
  logic             r_scan_ack;
  logic             w_capture;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let sync2 see this cycle's sync1.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= RAW_INPUTS;
      r_sync2 <= r_sync1;
    end
  end

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the if/case leaves it unassigned and a latch is never inferred.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      w_stable_next[i] = r_stable[i];
      w_cnt_next[i]    = '0;
      if (!FILTER_EN) begin
        w_stable_next[i] = r_sync2[i];
      end else if (r_sync2[i] != r_stable[i]) begin
        if (r_cnt[i] == CNT_LAST) begin
          w_stable_next[i] = r_sync2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // NOTE: the counter array is real per-channel state, not a RAM, so each
  // element is cleared on reset like any other flop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_stable <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_stable <= w_stable_next;
      r_cnt    <= w_cnt_next;
    end
  end

  assign w_rise    = w_stable_next & ~r_stable;
  assign w_fall    = ~w_stable_next & r_stable;
  assign w_capture = (r_state == CAPTURE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (SCAN_REQ) w_state_next = CAPTURE;
      CAPTURE:  w_state_next = ACK;
      ACK:      w_state_next = WAIT_REL;
      WAIT_REL: if (!SCAN_REQ) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  // Edges landing on the capture edge belong to the next scan, not this one.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_rise_pend  <= '0;
      r_fall_pend  <= '0;
      r_inputs     <= '0;
      r_rise_flags <= '0;
      r_fall_flags <= '0;
      r_scan_ack   <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_scan_ack <= w_capture;
      if (w_capture) begin
        r_inputs     <= r_stable;
        r_rise_flags <= r_rise_pend;
        r_fall_flags <= r_fall_pend;
        r_rise_pend  <= w_rise;
        r_fall_pend  <= w_fall;
      end else begin
        r_rise_pend  <= r_rise_pend | w_rise;
        r_fall_pend  <= r_fall_pend | w_fall;
      end
    end
  end

  assign SCAN_ACK   = r_scan_ack;
  assign INPUTS     = r_inputs;
  assign RISE_FLAGS = r_rise_flags;
  assign FALL_FLAGS = r_fall_flags;
  assign STABLE     = r_stable;

endmodule
